// File: rtl/image_pkg.sv
// Shared constants, types and helpers for the image ROM streaming path.
// The ROM holds one 256x256 image; the address is simply {line, column}.
package image_pkg;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 17;
  localparam int X_W    = 8;
  localparam int Y_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W:0]   w;
    logic [Y_W:0]   h;
  } roi_t;

  // IMG_W is a power of two, so y*IMG_W + x is a plain concatenation.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

  // Extents are summed two bits wider than the origin so they cannot wrap.
  function automatic logic roi_legal(input roi_t r);
    logic [X_W+1:0] x_end;
    logic [Y_W+1:0] y_end;
    x_end = {2'b00, r.x0} + {1'b0, r.w};
    y_end = {2'b00, r.y0} + {1'b0, r.h};
    return (r.w != '0) && (r.h != '0) &&
           (x_end <= (X_W+2)'(IMG_W)) && (y_end <= (Y_W+2)'(IMG_H));
  endfunction

endpackage

// File: rtl/rom_frame_streamer_if.sv
// Valid/ready pixel stream with frame and line markers.
interface rom_frame_streamer_if;
  import image_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output m_valid, m_data, m_sof, m_eol, m_eof,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_sof, m_eol, m_eof,
    output m_ready
  );
endinterface

// File: rtl/roi_raster_counter.sv
// Raster-order x/y walker over a latched ROI, with first/end-of-line/end-of-frame
// detection on the current position.
module roi_raster_counter
  import image_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           advance,
  input  roi_t           roi,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           first,
  output logic           eol,
  output logic           eof
);

  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic [X_W-1:0] x0_reg;
  logic [X_W:0]   x_last_reg;
  logic [Y_W:0]   y_last_reg;
  logic           first_reg, first_next;

  assign eol   = ({1'b0, x_reg} == x_last_reg);
  assign eof   = eol && ({1'b0, y_reg} == y_last_reg);
  assign first = first_reg;
  assign x     = x_reg;
  assign y     = y_reg;

  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    first_next = first_reg;
    if (load) begin
      x_next     = roi.x0;
      y_next     = roi.y0;
      first_next = 1'b1;
    end else if (advance) begin
      first_next = 1'b0;
      // The final position is held so the address stays on the last pixel.
      if (eol && !eof) begin
        x_next = x0_reg;
        y_next = y_reg + Y_W'(1);
      end else if (!eol) begin
        x_next = x_reg + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= '0;
      y_reg      <= '0;
      x0_reg     <= '0;
      x_last_reg <= '0;
      y_last_reg <= '0;
      first_reg  <= 1'b0;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      first_reg <= first_next;
      if (load) begin
        x0_reg     <= roi.x0;
        x_last_reg <= {1'b0, roi.x0} + roi.w - (X_W+1)'(1);
        y_last_reg <= {1'b0, roi.y0} + roi.h - (Y_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rom_frame_streamer.sv
// Walks an ROI of the image ROM in raster order and streams the registered
// ROM words as a valid/ready pixel stream with sof/eol/eof markers.
module rom_frame_streamer
  import image_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [X_W-1:0]              roi_x0,
  input  logic [Y_W-1:0]              roi_y0,
  input  logic [X_W:0]                roi_w,
  input  logic [Y_W:0]                roi_h,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_data,
  rom_frame_streamer_if.master        pix
);

  state_t state_reg, state_next;

  roi_t           roi_in;
  logic [X_W-1:0] cnt_x;
  logic [Y_W-1:0] cnt_y;
  logic           cnt_first, cnt_eol, cnt_eof;

  logic start_ok, legal, load, cnt_load, cnt_adv;
  logic cfg_err_next, done_next;

  logic              m_valid_reg;
  logic [DATA_W-1:0] m_data_reg;
  logic              m_sof_reg, m_eol_reg, m_eof_reg;
  logic              busy_reg, done_reg, cfg_err_reg;

  assign roi_in = '{x0: roi_x0, y0: roi_y0, w: roi_w, h: roi_h};
  assign legal  = roi_legal(roi_in);

  roi_raster_counter u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .advance (cnt_adv),
    .roi     (roi_in),
    .x       (cnt_x),
    .y       (cnt_y),
    .first   (cnt_first),
    .eol     (cnt_eol),
    .eof     (cnt_eof)
  );

  assign rom_addr = addr_of(cnt_x, cnt_y);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (cnt_load) state_next = RUN;
        RUN:     if (cnt_adv && cnt_eof) state_next = LAST;
        LAST:    if (pix.m_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control decode
  always_comb begin
    load         = !m_valid_reg || pix.m_ready;
    start_ok     = start && !abort && (state_reg == IDLE);
    cnt_load     = start_ok && legal;
    cfg_err_next = start_ok && !legal;
    cnt_adv      = (state_reg == RUN) && load && !abort;
    done_next    = (state_reg == LAST) && pix.m_ready && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_sof_reg   <= 1'b0;
      m_eol_reg   <= 1'b0;
      m_eof_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else if (abort) begin
      // The in-flight beat is dropped even if it is being accepted now.
      m_valid_reg <= 1'b0;
      m_sof_reg   <= 1'b0;
      m_eol_reg   <= 1'b0;
      m_eof_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_err_next;
      done_reg    <= done_next;
      if (cnt_load)  busy_reg <= 1'b1;
      if (done_next) busy_reg <= 1'b0;
      if (cnt_adv) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= rom_data;
        m_sof_reg   <= cnt_first;
        m_eol_reg   <= cnt_eol;
        m_eof_reg   <= cnt_eof;
      end else if (done_next) begin
        m_valid_reg <= 1'b0;
        m_sof_reg   <= 1'b0;
        m_eol_reg   <= 1'b0;
        m_eof_reg   <= 1'b0;
      end
    end
  end

  assign pix.m_valid = m_valid_reg;
  assign pix.m_data  = m_data_reg;
  assign pix.m_sof   = m_sof_reg;
  assign pix.m_eol   = m_eol_reg;
  assign pix.m_eof   = m_eof_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_rom_frame_streamer.sv
// Randomized frame-level bench for rom_frame_streamer: expected beats are built
// from the ROI rules over an injective ROM pattern and compared per frame.
module tb_rom_frame_streamer;
  import image_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [X_W-1:0]    roi_x0 = '0;
  logic [Y_W-1:0]    roi_y0 = '0;
  logic [X_W:0]      roi_w = '0;
  logic [Y_W:0]      roi_h = '0;
  logic              busy, done, cfg_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  rom_frame_streamer_if pix();

  rom_frame_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .roi_x0   (roi_x0),
    .roi_y0   (roi_y0),
    .roi_w    (roi_w),
    .roi_h    (roi_h),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix      (pix)
  );

  always #5 clk = ~clk;

  // Odd multiplier makes the low 16 bits a bijection of the address.
  function automatic logic [DATA_W-1:0] rom_word(input int a);
    logic [15:0] a16, s;
    a16 = 16'(a);
    s   = 16'(a16 * 16'd40503) ^ 16'h5A5A;
    return {a16[0] ^ a16[15], s};
  endfunction

  assign rom_data = rom_word(int'(rom_addr));

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic sof, eol, eof;
  } beat_t;

  beat_t obs[$];
  beat_t expq[$];
  int tests = 0, fails = 0;
  int done_cnt = 0, cfg_cnt = 0, stall_cnt = 0, stall_err = 0;
  int ready_mode = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready: always high, or a fair coin per cycle.
  initial begin
    pix.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix.m_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Handshake monitor and stall-stability watcher.
  initial begin
    beat_t cur, prev;
    logic  prev_hold;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = '{d: pix.m_data, sof: pix.m_sof, eol: pix.m_eol, eof: pix.m_eof};
      if (rst_n && !abort && prev_hold) begin
        stall_cnt++;
        if (!pix.m_valid || cur !== prev) stall_err++;
      end
      if (rst_n && !abort && pix.m_valid && pix.m_ready) obs.push_back(cur);
      if (done) done_cnt++;
      if (cfg_err) cfg_cnt++;
      prev_hold = rst_n && !abort && pix.m_valid && !pix.m_ready;
      prev = cur;
    end
  end

  task automatic build_exp(input int x0, input int y0, input int w, input int h);
    expq.delete();
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        beat_t b;
        b.d   = rom_word((y0 + yy) * IMG_W + x0 + xx);
        b.sof = (xx == 0) && (yy == 0);
        b.eol = (xx == w - 1);
        b.eof = (xx == w - 1) && (yy == h - 1);
        expq.push_back(b);
      end
    end
  endtask

  task automatic set_roi(input int x0, input int y0, input int w, input int h);
    roi_x0 = X_W'(x0);
    roi_y0 = Y_W'(y0);
    roi_w  = (X_W+1)'(w);
    roi_h  = (Y_W+1)'(h);
  endtask

  // Entered and left just after a rising edge; start is raised in cycle 0.
  task automatic run_frame(input string tag, input int x0, input int y0,
                           input int w, input int h, input int mode);
    int cyc, lim, d0, err;
    build_exp(x0, y0, w, h);
    obs.delete();
    ready_mode = mode;
    d0 = done_cnt;
    set_roi(x0, y0, w, h);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    lim = w * h * 8 + 100;
    while (cyc < lim) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_busy_at_done"}, busy, 1'b0);
    if (mode == 0) check_eq({tag, "_done_cycle"}, cyc, w * h + 2);
    @(posedge clk);
    #1;
    ready_mode = 0;
    check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({tag, "_valid_after"}, pix.m_valid, 1'b0);
    check_eq({tag, "_beats"}, obs.size(), expq.size());
    err = 0;
    for (int i = 0; i < expq.size() && i < obs.size(); i++)
      if (obs[i] !== expq[i]) err++;
    check_eq({tag, "_beat_errors"}, err, 0);
    if (obs.size() > 0) check_eq({tag, "_first_beat"}, obs[0], expq[0]);
    $display("[TB] frame %s roi=%0d,%0d,%0dx%0d beats=%0d cycles=%0d", tag, x0, y0, w, h, obs.size(), cyc);
  endtask

  initial begin
    int n_a, err, c0, d0, t;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             {busy, done, cfg_err, pix.m_valid, pix.m_sof, pix.m_eol, pix.m_eof}, 7'b0);
    check_eq("reset_addr", rom_addr, 16'h0);
    check_eq("reset_data", pix.m_data, 17'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame("roi_10_20", 10, 20, 3, 2, 0);
    run_frame("full", 0, 0, 256, 256, 0);
    stall_cnt = 0;
    stall_err = 0;
    run_frame("backpressure", 0, 0, 16, 4, 1);
    check_eq("stall_seen", stall_cnt > 0, 1'b1);
    check_eq("stall_stable", stall_err, 0);

    for (int k = 0; k < 6; k++) begin
      int w, h, x0, y0;
      w  = $urandom_range(1, 12);
      h  = $urandom_range(1, 5);
      x0 = $urandom_range(0, IMG_W - w);
      y0 = $urandom_range(0, IMG_H - h);
      run_frame($sformatf("rand%0d", k), x0, y0, w, h, 1);
    end
    check_eq("rand_stall_stable", stall_err, 0);

    // Illegal ROIs followed by a legal start one cycle later.
    for (int k = 0; k < 2; k++) begin
      c0 = cfg_cnt;
      if (k == 0) set_roi(5, 5, 0, 3);
      else        set_roi(250, 0, 10, 2);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check_eq($sformatf("cfg%0d_err", k), cfg_err, 1'b1);
      check_eq($sformatf("cfg%0d_busy", k), busy, 1'b0);
      check_eq($sformatf("cfg%0d_valid", k), pix.m_valid, 1'b0);
      run_frame($sformatf("after_cfg%0d", k), 3, 7, 4, 2, 0);
      check_eq($sformatf("cfg%0d_pulses", k), cfg_cnt - c0, 1);
    end

    // start and abort together while idle.
    set_roi(0, 0, 4, 4);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check_eq("start_abort_valid", pix.m_valid, 1'b0);

    // Abort after 100 beats of a full frame.
    obs.delete();
    d0 = done_cnt;
    set_roi(0, 0, 256, 256);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t = 0;
    while (obs.size() < 100 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("abort_reached_100", obs.size() >= 100, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    n_a = obs.size();
    check_eq("abort_valid", pix.m_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_no_more_beats", obs.size(), n_a);
    err = 0;
    for (int i = 0; i < n_a; i++)
      if (obs[i].d !== rom_word(i)) err++;
    check_eq("abort_prefix", err, 0);
    $display("[TB] frame abort beats_before_abort=%0d", n_a);
    run_frame("after_abort", 0, 0, 4, 2, 0);

    // Asynchronous reset mid-frame.
    set_roi(0, 0, 256, 256);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outputs",
             {busy, done, cfg_err, pix.m_valid, pix.m_sof, pix.m_eol, pix.m_eof}, 7'b0);
    check_eq("rst_mid_addr", rom_addr, 16'h0);
    check_eq("rst_mid_data", pix.m_data, 17'h0);
    $display("[TB] reset asserted mid-frame");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame("corner_1x1", 255, 255, 1, 1, 0);
    check_eq("corner_flags", {obs[0].sof, obs[0].eol, obs[0].eof}, 3'b111);
    check_eq("corner_data", obs[0].d, rom_word(65535));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
